// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg
//   Shared definitions for the ID/EX pipeline register and its forwarding
//   muxes.
//   - aluctr_e    : ALU operation codes driven on ALUctr
//   - REG_ZERO    : hard-wired zero register address (never forwarded)
//   - ctrl_t      : write-enable / memory control bits carried into EX
//   - BUBBLE_CTRL : control vector for an inert bubble
package id_ex_stage_pkg;

  // ALU operation codes, one name for every 4-bit ALUctr value
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_NOR  = 4'b0101,
    ALU_SLT  = 4'b0110,
    ALU_SLTU = 4'b0111,
    ALU_SLL  = 4'b1000,
    ALU_SRL  = 4'b1001,
    ALU_SRA  = 4'b1010,
    ALU_LUI  = 4'b1011,
    ALU_SLLV = 4'b1100,
    ALU_SRLV = 4'b1101,
    ALU_SRAV = 4'b1110,
    ALU_PASS = 4'b1111
  } aluctr_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

  // A bubble must never write the register file or touch memory
  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// id_ex_stage_fwd_mux
//   Operand forwarding for one source register: compares the source against
//   the EX/MEM and MEM/WB destinations and selects the newest value.
// Ports:
//   src            : source register address held in EX
//   reg_val        : register-file value captured with the instruction
//   exmem_regwrite : EX/MEM writes a register
//   exmem_wreg     : EX/MEM destination
//   exmem_result   : EX/MEM ALU result
//   memwb_regwrite : MEM/WB writes a register
//   memwb_wreg     : MEM/WB destination
//   memwb_data     : MEM/WB writeback data
//   fwd_val        : forwarded operand
module id_ex_stage_fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic [RA-1:0] src,
  input  logic [W-1:0]  reg_val,
  input  logic          exmem_regwrite,
  input  logic [RA-1:0] exmem_wreg,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RA-1:0] memwb_wreg,
  input  logic [W-1:0]  memwb_data,
  output logic [W-1:0]  fwd_val
);

  logic src_nonzero;
  logic hit_exmem;
  logic hit_memwb;

  // Register 0 is hard-wired, so a write aimed at it must never be forwarded
  assign src_nonzero = (src != RA'(REG_ZERO));
  assign hit_exmem   = exmem_regwrite & (exmem_wreg == src) & src_nonzero;
  assign hit_memwb   = memwb_regwrite & (memwb_wreg == src) & src_nonzero;

  // EX/MEM is the younger result, so it is checked first
  always_comb begin
    fwd_val = reg_val;
    if (hit_exmem)
      fwd_val = exmem_result;
    else if (hit_memwb)
      fwd_val = memwb_data;
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register feeding the ALU, with EX-stage operand forwarding
//   and load-use hazard detection.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   stall, flush          : hold EX contents / load a bubble (flush wins)
//   id_*                  : decoded instruction fields from ID
//   exmem_*, memwb_*      : downstream results used for forwarding
//   ex_valid              : EX holds a real instruction
//   ex_aluctr, ex_in1,
//   ex_in2, ex_shf, ex_pc : ALU inputs (in1/in2 forwarded)
//   ex_store_data         : forwarded rt for stores
//   ex_wreg, ex_regwrite,
//   ex_memread,
//   ex_memwrite,
//   ex_memtoreg           : registered destination and control bits
//   load_use              : combinational load-use hazard flag for hazard logic
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [W-1:0]  id_pc,
  input  logic [W-1:0]  id_rs_val,
  input  logic [W-1:0]  id_rt_val,
  input  logic [W-1:0]  id_imm,
  input  logic [RA-1:0] id_rs,
  input  logic [RA-1:0] id_rt,
  input  logic [RA-1:0] id_wreg,
  input  logic [4:0]    id_shamt,
  input  logic [3:0]    id_aluctr,
  input  logic          id_alusrc,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          exmem_regwrite,
  input  logic [RA-1:0] exmem_wreg,
  input  logic [W-1:0]  exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RA-1:0] memwb_wreg,
  input  logic [W-1:0]  memwb_data,
  output logic          ex_valid,
  output logic [3:0]    ex_aluctr,
  output logic [W-1:0]  ex_in1,
  output logic [W-1:0]  ex_in2,
  output logic [4:0]    ex_shf,
  output logic [W-1:0]  ex_pc,
  output logic [W-1:0]  ex_store_data,
  output logic [RA-1:0] ex_wreg,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          load_use
);

  logic          valid_q;
  logic [W-1:0]  pc_q;
  logic [W-1:0]  rs_val_q;
  logic [W-1:0]  rt_val_q;
  logic [W-1:0]  imm_q;
  logic [RA-1:0] rs_q;
  logic [RA-1:0] rt_q;
  logic [RA-1:0] wreg_q;
  logic [4:0]    shamt_q;
  logic [3:0]    aluctr_q;
  logic          alusrc_q;
  ctrl_t         ctrl_q;
  ctrl_t         id_ctrl;

  logic [W-1:0]  rs_fwd;
  logic [W-1:0]  rt_fwd;

  // Write enables of a non-instruction must not reach later stages
  assign id_ctrl = id_valid ? '{regwrite: id_regwrite, memread: id_memread,
                                memwrite: id_memwrite, memtoreg: id_memtoreg}
                            : BUBBLE_CTRL;

  // Pipeline register: flush loads an all-zero bubble ahead of stall, stall
  // holds everything, otherwise the ID fields are captured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      wreg_q   <= '0;
      shamt_q  <= '0;
      aluctr_q <= ALU_ADD;
      alusrc_q <= 1'b0;
      ctrl_q   <= BUBBLE_CTRL;
    end else if (flush) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rs_val_q <= '0;
      rt_val_q <= '0;
      imm_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      wreg_q   <= '0;
      shamt_q  <= '0;
      aluctr_q <= ALU_ADD;
      alusrc_q <= 1'b0;
      ctrl_q   <= BUBBLE_CTRL;
    end else if (!stall) begin
      valid_q  <= id_valid;
      pc_q     <= id_pc;
      rs_val_q <= id_rs_val;
      rt_val_q <= id_rt_val;
      imm_q    <= id_imm;
      rs_q     <= id_rs;
      rt_q     <= id_rt;
      wreg_q   <= id_wreg;
      shamt_q  <= id_shamt;
      aluctr_q <= id_aluctr;
      alusrc_q <= id_alusrc;
      ctrl_q   <= id_ctrl;
    end
  end

  // Forwarding stays live during a stall so a held instruction picks up
  // writebacks that land while it waits
  id_ex_stage_fwd_mux #(.W(W), .RA(RA)) u_rs_fwd (
    .src            (rs_q),
    .reg_val        (rs_val_q),
    .exmem_regwrite (exmem_regwrite),
    .exmem_wreg     (exmem_wreg),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_wreg     (memwb_wreg),
    .memwb_data     (memwb_data),
    .fwd_val        (rs_fwd)
  );

  id_ex_stage_fwd_mux #(.W(W), .RA(RA)) u_rt_fwd (
    .src            (rt_q),
    .reg_val        (rt_val_q),
    .exmem_regwrite (exmem_regwrite),
    .exmem_wreg     (exmem_wreg),
    .exmem_result   (exmem_result),
    .memwb_regwrite (memwb_regwrite),
    .memwb_wreg     (memwb_wreg),
    .memwb_data     (memwb_data),
    .fwd_val        (rt_fwd)
  );

  assign ex_valid      = valid_q;
  assign ex_aluctr     = aluctr_q;
  assign ex_in1        = rs_fwd;
  assign ex_in2        = alusrc_q ? imm_q : rt_fwd;
  assign ex_shf        = shamt_q;
  assign ex_pc         = pc_q;
  assign ex_store_data = rt_fwd;
  assign ex_wreg       = wreg_q;
  assign ex_regwrite   = ctrl_q.regwrite;
  assign ex_memread    = ctrl_q.memread;
  assign ex_memwrite   = ctrl_q.memwrite;
  assign ex_memtoreg   = ctrl_q.memtoreg;

  // A load in EX whose destination is a source of the ID instruction cannot
  // be satisfied by forwarding; register 0 never creates a dependency
  assign load_use = valid_q & ctrl_q.memread & (wreg_q != RA'(REG_ZERO)) &
                    ((wreg_q == id_rs) | (wreg_q == id_rt)) & id_valid;

endmodule
